// File: rtl/mouse_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets into movement strobes and a clamped cursor.
// Define MOUSE_POS_TRACK_EN to accumulate MOUSE_X/MOUSE_Y; otherwise they sit at centre.
module mouse_packet_assembler #(
    parameter int MAX_X          = 160,
    parameter int MAX_Y          = 120,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic       READ_ENABLE,
    output logic       PACKET_VALID,
    output logic [7:0] STATUS,
    output logic [8:0] DX,
    output logic [8:0] DY,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic       SYNC_LOST,
    output logic [7:0] ERROR_COUNT
);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } state_t;

    localparam logic [23:0] T_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  X_HOME = 8'(MAX_X / 2);
    localparam logic [7:0]  Y_HOME = 8'(MAX_Y / 2);

    state_t      state;
    logic [7:0]  status_q;
    logic [7:0]  xbyte_q;
    logic [7:0]  ybyte_q;
    logic [23:0] tcount;

    logic        code_ok;
    logic        discard;
    logic [8:0]  dx_next;
    logic [8:0]  dy_next;

    assign code_ok = (BYTE_ERROR_CODE == 2'b00);

    // Overflow forces the delta to the extreme in the direction of the sign bit.
    always_comb begin
        dx_next = {status_q[4], xbyte_q};
        dy_next = {status_q[5], ybyte_q};
        if (status_q[6])
            dx_next = status_q[4] ? 9'h100 : 9'h0FF;
        if (status_q[7])
            dy_next = status_q[5] ? 9'h100 : 9'h0FF;
    end

    always_comb begin
        discard = 1'b0;
        if (READ_ENABLE) begin
            unique case (state)
                WAIT_B0: discard = BYTE_READY && !(code_ok && BYTE_READ[3]);
                WAIT_B1,
                WAIT_B2: discard = BYTE_READY ? !code_ok : (tcount == T_LAST);
                default: discard = 1'b0;
            endcase
        end
    end

`ifdef MOUSE_POS_TRACK_EN
    localparam logic signed [9:0] X_LIM = 10'(MAX_X - 1);
    localparam logic signed [9:0] Y_LIM = 10'(MAX_Y - 1);

    function automatic logic [7:0] clamp_pos(
        input logic [7:0]        cur,
        input logic [8:0]        d,
        input logic signed [9:0] lim
    );
        logic signed [9:0] sum;
        sum = $signed({2'b00, cur}) + $signed({d[8], d});
        if (sum < 10'sd0)
            clamp_pos = 8'd0;
        else if (sum > lim)
            clamp_pos = lim[7:0];
        else
            clamp_pos = sum[7:0];
    endfunction
`else
    assign MOUSE_X = X_HOME;
    assign MOUSE_Y = Y_HOME;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= WAIT_B0;
            status_q     <= 8'h00;
            xbyte_q      <= 8'h00;
            ybyte_q      <= 8'h00;
            tcount       <= 24'd0;
            READ_ENABLE  <= 1'b0;
            PACKET_VALID <= 1'b0;
            STATUS       <= 8'h00;
            DX           <= 9'd0;
            DY           <= 9'd0;
            SYNC_LOST    <= 1'b0;
            ERROR_COUNT  <= 8'd0;
`ifdef MOUSE_POS_TRACK_EN
            MOUSE_X      <= X_HOME;
            MOUSE_Y      <= Y_HOME;
`endif
        end else begin
            READ_ENABLE  <= ENABLE;
            PACKET_VALID <= 1'b0;
            SYNC_LOST    <= discard;
            if (discard && ERROR_COUNT != 8'hFF)
                ERROR_COUNT <= ERROR_COUNT + 8'd1;

            if (!READ_ENABLE) begin
                state  <= WAIT_B0;
                tcount <= 24'd0;
            end else begin
                unique case (state)
                    WAIT_B0: begin
                        tcount <= 24'd0;
                        if (BYTE_READY && code_ok && BYTE_READ[3]) begin
                            status_q <= BYTE_READ;
                            state    <= WAIT_B1;
                        end
                    end
                    WAIT_B1: begin
                        if (BYTE_READY) begin
                            tcount <= 24'd0;
                            if (code_ok) begin
                                xbyte_q <= BYTE_READ;
                                state   <= WAIT_B2;
                            end else begin
                                state <= WAIT_B0;
                            end
                        end else if (tcount == T_LAST) begin
                            tcount <= 24'd0;
                            state  <= WAIT_B0;
                        end else begin
                            tcount <= tcount + 24'd1;
                        end
                    end
                    WAIT_B2: begin
                        if (BYTE_READY) begin
                            tcount <= 24'd0;
                            if (code_ok) begin
                                ybyte_q <= BYTE_READ;
                                state   <= UPDATE;
                            end else begin
                                state <= WAIT_B0;
                            end
                        end else if (tcount == T_LAST) begin
                            tcount <= 24'd0;
                            state  <= WAIT_B0;
                        end else begin
                            tcount <= tcount + 24'd1;
                        end
                    end
                    UPDATE: begin
                        STATUS       <= status_q;
                        DX           <= dx_next;
                        DY           <= dy_next;
                        PACKET_VALID <= 1'b1;
`ifdef MOUSE_POS_TRACK_EN
                        MOUSE_X      <= clamp_pos(MOUSE_X, dx_next, X_LIM);
                        MOUSE_Y      <= clamp_pos(MOUSE_Y, dy_next, Y_LIM);
`endif
                        tcount       <= 24'd0;
                        state        <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Randomised bench for mouse_packet_assembler against a queue-based packet model.
// Honour MOUSE_POS_TRACK_EN the same way the design does.
module tb_mouse_packet_assembler;

    localparam int MX = 160;
    localparam int MY = 120;
    localparam int TO = 64;
`ifdef MOUSE_POS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic       READ_ENABLE;
    logic       PACKET_VALID;
    logic [7:0] STATUS;
    logic [8:0] DX;
    logic [8:0] DY;
    logic [7:0] MOUSE_X;
    logic [7:0] MOUSE_Y;
    logic       SYNC_LOST;
    logic [7:0] ERROR_COUNT;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_seen  = 0;

    logic [7:0] q[$];
    int m_err;
    int m_x;
    int m_y;

    mouse_packet_assembler #(
        .MAX_X(MX), .MAX_Y(MY), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY), .READ_ENABLE(READ_ENABLE),
        .PACKET_VALID(PACKET_VALID), .STATUS(STATUS), .DX(DX), .DY(DY),
        .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .SYNC_LOST(SYNC_LOST),
        .ERROR_COUNT(ERROR_COUNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (PACKET_VALID === 1'b1) pv_seen++;

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(logic [7:0] st, logic [7:0] b, int ovf, int sgn);
        if (st[ovf]) return st[sgn] ? -256 : 255;
        return st[sgn] ? int'(b) - 256 : int'(b);
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 0;
        m_x = MX / 2;
        m_y = MY / 2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] c);
        @(negedge CLK);
        BYTE_READ = b;
        BYTE_ERROR_CODE = c;
        BYTE_READY = 1'b1;
        @(negedge CLK);
        BYTE_READY = 1'b0;
    endtask

    // Send one byte, advance the model and compare everything it predicts.
    task automatic drive(input logic [7:0] b, input logic [1:0] c, input string tag);
        bit disc = 0;
        bit emit = 0;
        logic [7:0] st = 8'h00;
        int dx = 0;
        int dy = 0;
        if (q.size() == 0) begin
            if (c == 2'b00 && b[3]) q.push_back(b);
            else disc = 1;
        end else if (c != 2'b00) begin
            q.delete();
            disc = 1;
        end else begin
            q.push_back(b);
        end
        if (q.size() == 3) begin
            emit = 1;
            st = q[0];
            dx = delta(q[0], q[1], 6, 4);
            dy = delta(q[0], q[2], 7, 5);
            if (TRACK) begin
                m_x = clampi(m_x + dx, MX - 1);
                m_y = clampi(m_y + dy, MY - 1);
            end
            q.delete();
        end
        if (disc && m_err < 255) m_err++;

        send_byte(b, c);
        n_checks++;
        if (SYNC_LOST !== disc) begin
            n_fail++;
            $display("FAIL %s sync_lost got %b want %b", tag, SYNC_LOST, disc);
        end
        n_checks++;
        if (ERROR_COUNT !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL %s error_count got %0d want %0d", tag, ERROR_COUNT, m_err);
        end
        if (emit) begin
            @(negedge CLK);
            n_checks++;
            if (PACKET_VALID !== 1'b1 || STATUS !== st ||
                int'($signed(DX)) != dx || int'($signed(DY)) != dy) begin
                n_fail++;
                $display("FAIL %s packet got pv=%b st=%h dx=%0d dy=%0d want pv=1 st=%h dx=%0d dy=%0d",
                         tag, PACKET_VALID, STATUS, $signed(DX), $signed(DY), st, dx, dy);
            end
            n_checks++;
            if (MOUSE_X !== 8'(m_x) || MOUSE_Y !== 8'(m_y)) begin
                n_fail++;
                $display("FAIL %s position got %0d,%0d want %0d,%0d",
                         tag, MOUSE_X, MOUSE_Y, m_x, m_y);
            end
            @(negedge CLK);
            n_checks++;
            if (PACKET_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pv_width got %b want 0", tag, PACKET_VALID);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (PACKET_VALID !== 1'b0 || STATUS !== 8'h00 || DX !== 9'd0 || DY !== 9'd0 ||
            SYNC_LOST !== 1'b0 || ERROR_COUNT !== 8'd0 || READ_ENABLE !== 1'b0 ||
            MOUSE_X !== 8'(MX / 2) || MOUSE_Y !== 8'(MY / 2)) begin
            n_fail++;
            $display("FAIL %s got pv=%b st=%h dx=%h dy=%h sl=%b ec=%0d re=%b x=%0d y=%0d want reset values",
                     tag, PACKET_VALID, STATUS, DX, DY, SYNC_LOST, ERROR_COUNT,
                     READ_ENABLE, MOUSE_X, MOUSE_Y);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ENABLE = 1'b1;
        BYTE_READY = 1'b0;
        BYTE_READ = 8'h00;
        BYTE_ERROR_CODE = 2'b00;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if (READ_ENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL read_enable_latency got %b want 1", READ_ENABLE);
        end
    endtask

    task automatic test_basic();
        drive(8'h08, 2'b00, "basic_b0");
        drive(8'h05, 2'b00, "basic_b1");
        drive(8'h03, 2'b00, "basic_b2");
    endtask

    task automatic test_resync();
        drive(8'h00, 2'b00, "resync_bad");
        drive(8'h08, 2'b00, "resync_b0");
        drive(8'h01, 2'b00, "resync_b1");
        drive(8'h01, 2'b00, "resync_b2");
    endtask

    task automatic test_byte_error();
        drive(8'h08, 2'b00, "berr_b0");
        drive(8'h10, 2'b01, "berr_parity");
        drive(8'h08, 2'b00, "berr_n0");
        drive(8'h00, 2'b00, "berr_n1");
        drive(8'h00, 2'b00, "berr_n2");
    endtask

    task automatic test_overflow();
        drive(8'h58, 2'b00, "ovf_b0");
        drive(8'h00, 2'b00, "ovf_b1");
        drive(8'h00, 2'b00, "ovf_b2");
        for (int i = 0; i < 3; i++) begin
            drive(8'h08, 2'b00, "sat_b0");
            drive(8'h7F, 2'b00, "sat_b1");
            drive(8'h00, 2'b00, "sat_b2");
        end
        drive(8'hB8, 2'b00, "ovfy_b0");
        drive(8'h00, 2'b00, "ovfy_b1");
        drive(8'h00, 2'b00, "ovfy_b2");
    endtask

    task automatic test_timeout();
        int k;
        drive(8'h08, 2'b00, "to_b0");
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge CLK);
            if (SYNC_LOST === 1'b1) begin
                k = i;
                break;
            end
        end
        q.delete();
        if (m_err < 255) m_err++;
        n_checks++;
        if (k != TO) begin
            n_fail++;
            $display("FAIL timeout_cycles got %0d want %0d", k, TO);
        end
        n_checks++;
        if (ERROR_COUNT !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL timeout_errcnt got %0d want %0d", ERROR_COUNT, m_err);
        end
        drive(8'h08, 2'b00, "to_n0");
        repeat (TO / 2) @(negedge CLK);
        drive(8'h02, 2'b00, "to_n1");
        repeat (TO / 2) @(negedge CLK);
        drive(8'h02, 2'b00, "to_n2");
    endtask

    task automatic test_enable_drop();
        drive(8'h08, 2'b00, "en_b0");
        drive(8'h01, 2'b00, "en_b1");
        ENABLE = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (READ_ENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop read_enable got %b want 0", READ_ENABLE);
        end
        repeat (2) @(negedge CLK);
        ENABLE = 1'b1;
        repeat (2) @(negedge CLK);
        q.delete();
        n_checks++;
        if (ERROR_COUNT !== 8'(m_err) || SYNC_LOST !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_noerr got ec=%0d sl=%b want ec=%0d sl=0",
                     ERROR_COUNT, SYNC_LOST, m_err);
        end
        drive(8'h18, 2'b00, "en_n0");
        drive(8'h02, 2'b00, "en_n1");
        drive(8'h03, 2'b00, "en_n2");
    endtask

    task automatic test_reset_mid_packet();
        int pv0;
        drive(8'h08, 2'b00, "rst_b0");
        drive(8'h05, 2'b00, "rst_b1");
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_values("reset_mid");
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        pv0 = pv_seen;
        drive(8'h03, 2'b00, "rst_lone");
        repeat (3) @(negedge CLK);
        n_checks++;
        if (pv_seen != pv0) begin
            n_fail++;
            $display("FAIL reset_mid_no_pv got %0d pulses want 0", pv_seen - pv0);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [1:0] c;
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) != 0) b[3] = 1'b1;
            c = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(b, c, "random");
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 270; i++)
            drive(8'h00, 2'b00, "saturate");
        n_checks++;
        if (ERROR_COUNT !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturate_final got %0d want 255", ERROR_COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_byte_error();
        test_overflow();
        test_timeout();
        test_enable_drop();
        test_reset_mid_packet();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
